// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : instruction_fetch_unit                                        |
// | Brief    : PC sequencing, instruction memory fetch, 2-entry decode queue |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module instruction_fetch_unit #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    INSTR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] LAST_ADDR   = 52
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic [ADDR_WIDTH-1:0]  PC,
   output logic [ADDR_WIDTH-1:0]  NewPC,
   output logic                   PCWrite,
   output logic [ADDR_WIDTH-1:0]  IMemAddr,
   output logic                   IMemReadEn,
   input  logic [INSTR_WIDTH-1:0] IMemData,
   input  logic                   Stall,
   input  logic                   BranchTaken,
   input  logic [ADDR_WIDTH-1:0]  BranchTarget,
   output logic [INSTR_WIDTH-1:0] Instr,
   output logic [ADDR_WIDTH-1:0]  InstrPC,
   output logic                   InstrValid,
   input  logic                   DecodeReady
);

   localparam logic [0:0]            c_BOOT    = 1'b0;
   localparam logic [0:0]            c_RUN     = 1'b1;
   localparam logic [ADDR_WIDTH-1:0] c_PC_STEP = ADDR_WIDTH'(4);

   logic [0:0]             r_state;
   logic [0:0]             w_next_state;

   logic [INSTR_WIDTH-1:0] r_fifo_instr [2];
   logic [ADDR_WIDTH-1:0]  r_fifo_pc    [2];
   logic                   r_head;
   logic [1:0]             r_count;
   logic                   r_req_pending;
   logic [ADDR_WIDTH-1:0]  r_req_addr;

   logic                   w_run;
   logic                   w_deq;
   logic                   w_branch;
   logic                   w_issue;
   logic                   w_enq;
   logic                   w_wr_idx;
   logic [2:0]             w_credit_used;

   function automatic logic [ADDR_WIDTH-1:0] f_wrap(input logic [ADDR_WIDTH-1:0] x);
      return (x > LAST_ADDR) ? '0 : x;
   endfunction

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge Clock) begin
      if (Reset) r_state <= c_BOOT;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_BOOT:  w_next_state = c_RUN;
         c_RUN:   w_next_state = c_RUN;
         default: w_next_state = c_BOOT;
      endcase
   end

   always_comb begin
      PCWrite    = 1'b0;
      IMemReadEn = 1'b0;
      NewPC      = PC;
      IMemAddr   = PC;
      if (Reset) begin
         NewPC = '0;
      end else if (w_branch) begin
         PCWrite = 1'b1;
         NewPC   = f_wrap(BranchTarget);
      end else if (w_issue) begin
         PCWrite    = 1'b1;
         IMemReadEn = 1'b1;
         NewPC      = f_wrap(PC + c_PC_STEP);
      end
   end

   // ---------------------------------------------------------------- fetch control
   assign w_run    = (r_state == c_RUN);
   assign w_deq    = InstrValid & DecodeReady;
   assign w_branch = w_run & BranchTaken;

   // Queue slots already promised: occupied entries plus the word in flight,
   // less the one decode is taking this cycle.
   assign w_credit_used = {1'b0, r_count} + {2'b00, r_req_pending} - {2'b00, w_deq};
   assign w_issue       = w_run & ~BranchTaken & ~Stall & (w_credit_used < 3'd2);

   // A request is only ever in flight for one cycle, so a branch in the data
   // cycle is exactly the squash condition.
   assign w_enq    = r_req_pending & ~w_branch;
   assign w_wr_idx = r_head ^ r_count[0];

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_req_pending   <= 1'b0;
         r_req_addr      <= '0;
         r_head          <= 1'b0;
         r_count         <= 2'd0;
         r_fifo_instr[0] <= '0;
         r_fifo_instr[1] <= '0;
         r_fifo_pc[0]    <= '0;
         r_fifo_pc[1]    <= '0;
      end else begin
         r_req_pending <= w_issue;
         if (w_issue) r_req_addr <= PC;

         if (w_enq) begin
            r_fifo_instr[w_wr_idx] <= IMemData;
            r_fifo_pc[w_wr_idx]    <= r_req_addr;
         end

         if (w_deq) r_head <= ~r_head;

         if (w_branch) r_count <= 2'd0;
         else          r_count <= r_count + {1'b0, w_enq} - {1'b0, w_deq};
      end
   end

   assign Instr      = r_fifo_instr[r_head];
   assign InstrPC    = r_fifo_pc[r_head];
   assign InstrValid = (r_count != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_instruction_fetch_unit                                     |
// | Brief    : Scoreboard bench with PC register and memory environment      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_instruction_fetch_unit;

   localparam logic [31:0] c_LAST = 32'd52;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic [31:0] PC = '0;
   logic [31:0] NewPC;
   logic        PCWrite;
   logic [31:0] IMemAddr;
   logic        IMemReadEn;
   logic [31:0] IMemData = '0;
   logic        Stall = 1'b0;
   logic        BranchTaken = 1'b0;
   logic [31:0] BranchTarget = '0;
   logic [31:0] Instr;
   logic [31:0] InstrPC;
   logic        InstrValid;
   logic        DecodeReady = 1'b1;

   instruction_fetch_unit #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .LAST_ADDR(c_LAST)) dut (
      .Clock(Clock), .Reset(Reset), .PC(PC), .NewPC(NewPC), .PCWrite(PCWrite),
      .IMemAddr(IMemAddr), .IMemReadEn(IMemReadEn), .IMemData(IMemData),
      .Stall(Stall), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
      .Instr(Instr), .InstrPC(InstrPC), .InstrValid(InstrValid), .DecodeReady(DecodeReady)
   );

   always #5 Clock = ~Clock;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned n_deq    = 0;
   logic [31:0] pc_rst   = '0;
   logic [31:0] salt     = '0;
   logic [31:0] exp_q [$];
   logic [31:0] gen      = '0;
   logic [31:0] e_pc;
   bit          boot_seen = 0, in_run = 0, prev_branch = 0;

   function automatic logic [31:0] wrap(input logic [31:0] x);
      return (x > c_LAST) ? 32'd0 : x;
   endfunction

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endfunction

   // Environment: PC register and synchronous memory (word = address ^ salt)
   always @(posedge Clock) begin
      if (Reset)        PC <= pc_rst;
      else if (PCWrite) PC <= NewPC;
      if (IMemReadEn) IMemData <= IMemAddr ^ salt;
      else            IMemData <= $urandom;
   end

   // Monitor: PC-port rules every cycle, delivered stream against program order
   always @(negedge Clock) begin
      if (Reset) begin
         chk("rst_pcwrite", PCWrite, 0);
         chk("rst_readen", IMemReadEn, 0);
         chk("rst_newpc", NewPC, 0);
         boot_seen   = 0;
         in_run      = 0;
         prev_branch = 0;
         exp_q.delete();
         gen = pc_rst;
      end else begin
         in_run    = boot_seen;
         boot_seen = 1;
         if (prev_branch) chk("valid_after_branch", InstrValid, 0);
         if (!in_run) begin
            chk("boot_readen", IMemReadEn, 0);
            chk("boot_pcwrite", PCWrite, 0);
            chk("boot_valid", InstrValid, 0);
         end else if (BranchTaken) begin
            chk("br_pcwrite", PCWrite, 1);
            chk("br_newpc", NewPC, wrap(BranchTarget));
            chk("br_readen", IMemReadEn, 0);
         end else if (Stall) begin
            chk("stall_pcwrite", PCWrite, 0);
            chk("stall_readen", IMemReadEn, 0);
         end else if (IMemReadEn) begin
            chk("issue_pcwrite", PCWrite, 1);
            chk("issue_newpc", NewPC, wrap(PC + 32'd4));
            chk("issue_addr", IMemAddr, PC);
         end else begin
            chk("idle_pcwrite", PCWrite, 0);
         end
         if (InstrValid && DecodeReady) begin
            while (exp_q.size() < 4) begin
               exp_q.push_back(gen);
               gen = wrap(gen + 32'd4);
            end
            e_pc = exp_q.pop_front();
            chk("deq_instrpc", InstrPC, e_pc);
            chk("deq_instr", Instr, e_pc ^ salt);
            n_deq++;
         end
         prev_branch = in_run && BranchTaken;
         if (prev_branch) begin
            exp_q.delete();
            gen = wrap(BranchTarget);
         end
      end
   end

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic wait_valid_pc(input string name, input logic [31:0] req);
      bit seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         if (InstrValid) seen = 1;
         else step();
      end
      if (seen) chk(name, InstrPC, req);
      else      chk({name, "_timeout"}, 0, 1);
   endtask

   task automatic do_reset(input logic [31:0] start);
      Reset  = 1'b1;
      pc_rst = start;
      step();
      step();
      Reset = 1'b0;
   endtask

   initial begin
      int unsigned base;
      bit found;

      // Startup latency and throughput
      do_reset(32'd0);
      #1 chk("boot_cycle_readen", IMemReadEn, 0);
      step();
      chk("first_issue", IMemReadEn, 1);
      chk("first_issue_addr", IMemAddr, 0);
      step();
      chk("latency_not_yet", InstrValid, 0);
      step();
      chk("first_valid", InstrValid, 1);
      chk("first_instr", Instr, 0);
      chk("first_instrpc", InstrPC, 0);
      for (int i = 1; i <= 3; i++) begin
         step();
         chk("stream_valid", InstrValid, 1);
         chk("stream_instrpc", InstrPC, 32'(4 * i));
      end

      // Backpressure fills the queue and halts fetch
      DecodeReady = 1'b0;
      repeat (6) step();
      chk("full_readen", IMemReadEn, 0);
      chk("full_pcwrite", PCWrite, 0);
      chk("full_valid", InstrValid, 1);
      DecodeReady = 1'b1;
      step();

      // Branch with a word in flight and the queue occupied
      BranchTaken  = 1'b1;
      BranchTarget = 32'd20;
      #1;
      chk("branch_pcwrite", PCWrite, 1);
      chk("branch_newpc", NewPC, 32'd20);
      step();
      BranchTaken = 1'b0;
      chk("branch_flush", InstrValid, 0);
      wait_valid_pc("post_branch_pc", 32'd20);
      repeat (3) step();

      // Branch beyond LAST_ADDR wins over Stall
      BranchTaken  = 1'b1;
      Stall        = 1'b1;
      BranchTarget = 32'd60;
      #1;
      chk("br60_newpc", NewPC, 0);
      chk("br60_pcwrite", PCWrite, 1);
      step();
      BranchTaken = 1'b0;
      Stall       = 1'b0;
      wait_valid_pc("post_br60_pc", 32'd0);

      // Three-cycle stall mid-stream
      Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("stall3_pcwrite", PCWrite, 0);
         step();
      end
      Stall = 1'b0;
      repeat (6) step();

      // Wrap from 48
      do_reset(32'd48);
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (IMemReadEn && IMemAddr == 32'd52) begin
            found = 1;
            chk("wrap_newpc", NewPC, 0);
         end else begin
            step();
         end
      end
      if (!found) chk("wrap_issue_52_timeout", 0, 1);
      repeat (8) step();

      // Randomized traffic
      salt = $urandom;
      do_reset(32'd0);
      base = n_deq;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 249) == 0) begin
            pc_rst = 32'($urandom_range(0, 13) * 4);
            Reset  = 1'b1;
         end else begin
            Reset = 1'b0;
         end
         Stall       = ($urandom_range(0, 4) == 0);
         BranchTaken = ($urandom_range(0, 12) == 0);
         BranchTarget = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                                    : 32'($urandom_range(0, 17) * 4);
         DecodeReady = ($urandom_range(0, 3) != 0);
         step();
      end
      Reset       = 1'b0;
      Stall       = 1'b0;
      BranchTaken = 1'b0;
      DecodeReady = 1'b1;
      repeat (6) step();
      chk("random_progress", 32'(n_deq - base > 300), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
